// File: rtl/conv_seq_pkg.sv
// Shared types and defaults for the convolution frame sequencer.
package conv_seq_pkg;

  // Sequencer state | meaning
  // IDLE            | waiting for start
  // RUN             | issuing reads in raster order as grants arrive
  // DRAIN           | all reads issued, waiting for in-flight writes
  // DONE            | one-cycle completion, bumps the frame counter
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int DEF_FRAME_W = 640;
  localparam int DEF_FRAME_H = 480;

  // Smallest address width that covers every pixel of a w x h frame.
  function automatic int addr_width(input int w, input int h);
    int n;
    n = w * h;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/valid_addr_delay.sv
// Fixed-depth valid+address shift register. any_valid reports entries that
// have not yet reached the output stage (including the one entering now), so a
// controller can tell whether more writes are still to come.
module valid_addr_delay #(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              valid_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              any_valid
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = ^{clk, reset, flush};
      assign valid_out = valid_in;
      assign addr_out  = addr_in;
      assign any_valid = 1'b0;
    end else begin : g_shift
      logic [DEPTH-1:0]  vld;
      logic [ADDR_W-1:0] adr [DEPTH];
      logic              pend;

      // Valid bits shift every cycle; flush drops everything in flight.
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          vld <= '0;
        end else begin
          vld[0] <= valid_in;
          for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
        end
      end

      // Addresses ride alongside the valid bits; only reset clears them.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) adr[i] <= '0;
        end else begin
          adr[0] <= addr_in;
          for (int i = 1; i < DEPTH; i++) adr[i] <= adr[i-1];
        end
      end

      // Pending = entering entry or any stage short of the output.
      always_comb begin
        pend = valid_in;
        for (int i = 0; i < DEPTH - 1; i++) pend = pend | vld[i];
      end

      assign valid_out = vld[DEPTH-1];
      assign addr_out  = adr[DEPTH-1];
      assign any_valid = pend;
    end
  endgenerate

endmodule

// File: rtl/conv_frame_sequencer.sv
// Drives one raster-order read pass over a frame and mirrors each read as a
// write L = RD_LAT + ENG_LAT cycles later.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one read per granted cycle, address advances by one
// DRAIN | last read issued, waiting for pending writes
// DONE  | done pulse, frame_count increments
module conv_frame_sequencer
  import conv_seq_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int ADDR_W  = addr_width(DEF_FRAME_W, DEF_FRAME_H),
  parameter int RD_LAT  = 2,
  parameter int ENG_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       mem_grant,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic [$clog2(FRAME_W)-1:0] pix_x,
  output logic [$clog2(FRAME_H)-1:0] pix_y,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           frame_count
);

  localparam int XW = $clog2(FRAME_W);
  localparam int YW = $clog2(FRAME_H);
  localparam int L  = RD_LAT + ENG_LAT;
  localparam logic [XW-1:0]     X_LAST = XW'(FRAME_W - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(FRAME_W * FRAME_H - 1);

  seq_state_t        state, state_nx;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic              issue, take_start, finish, any_pending;

  // Next state and per-cycle strobes; abort overrides everything.
  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    take_start = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx   = RUN;
        take_start = 1'b1;
      end
      RUN: if (mem_grant) begin
        issue = 1'b1;
        if (addr == A_LAST) state_nx = DRAIN;
      end
      DRAIN: if (!any_pending) state_nx = DONE;
      DONE: begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx   = IDLE;
      issue      = 1'b0;
      take_start = 1'b0;
      finish     = 1'b0;
    end
  end

  // State, raster counters and registered read outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_count <= '0;
    end else begin
      state <= state_nx;
      rd_en <= issue;
      if (take_start) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
      end
      if (issue) begin
        rd_addr <= addr;
        pix_x   <= x;
        pix_y   <= y;
        addr    <= addr + 1'b1;
        if (x == X_LAST) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      if (finish) frame_count <= frame_count + 1'b1;
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = finish;

  valid_addr_delay #(
    .DEPTH (L),
    .ADDR_W(ADDR_W)
  ) u_delay (
    .clk      (clk),
    .reset    (reset),
    .flush    (abort),
    .valid_in (rd_en),
    .addr_in  (rd_addr),
    .valid_out(wr_en),
    .addr_out (wr_addr),
    .any_valid(any_pending)
  );

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench: a cycle-level behavioural model built from pixel
// indices and timestamped write queue, compared against the DUT every cycle.
module tb_conv_frame_sequencer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int RL = 2;
  localparam int EL = 1;
  localparam int L  = RL + EL;
  localparam int AW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset, start, abort, mem_grant;
  logic          rd_en, wr_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [1:0]    pix_x, pix_y;
  logic [CW-1:0] frame_count;

  conv_frame_sequencer #(
    .FRAME_W(W), .FRAME_H(H), .ADDR_W(AW), .RD_LAT(RL), .ENG_LAT(EL), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mem_grant(mem_grant),
    .rd_en(rd_en), .rd_addr(rd_addr), .pix_x(pix_x), .pix_y(pix_y),
    .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state
  int cyc = 0;
  bit m_reading, m_waiting;
  int next_pix, done_due, m_fc, m_nrd;
  bit m_rd_en, m_wr_en, m_busy, m_done;
  int m_rd_addr, m_px, m_py, m_wr_addr;
  int q_due[$];
  int q_addr[$];
  int gmode = 0;
  bit chk_on = 0;

  // Observations of the DUT for literal checks
  int obs_rd, obs_wr, obs_done, first_rd_cyc, last_rd_cyc, first_wr_cyc, last_wr_cyc;
  int done_cyc, first_rd_addr, late_wr, cut_edge;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic clear_obs();
    obs_rd = 0; obs_wr = 0; obs_done = 0; first_rd_cyc = 0; last_rd_cyc = 0;
    first_wr_cyc = 0; last_wr_cyc = 0; done_cyc = 0; first_rd_addr = -1;
    late_wr = 0; cut_edge = 1 << 30;
  endtask

  // Advance the model over one clock edge using the inputs sampled there.
  task automatic model_edge();
    bit iss, was_idle;
    cyc++;
    if (reset) begin
      m_reading = 0; m_waiting = 0; next_pix = 0; m_fc = 0; m_nrd = 0;
      m_rd_en = 0; m_rd_addr = 0; m_px = 0; m_py = 0; m_wr_en = 0;
      q_due.delete(); q_addr.delete();
    end else begin
      iss = m_reading && mem_grant && !abort;
      was_idle = !m_reading && !m_waiting;
      if (abort) begin q_due.delete(); q_addr.delete(); end
      if (m_waiting && cyc == done_due + 1) begin
        m_waiting = 0;
        if (!abort) m_fc = (m_fc + 1) % (1 << CW);
      end
      m_rd_en = iss;
      if (iss) begin
        m_rd_addr = next_pix; m_px = next_pix % W; m_py = next_pix / W;
        q_due.push_back(cyc + L); q_addr.push_back(next_pix);
        m_nrd++;
        if (next_pix == N - 1) begin
          m_reading = 0; m_waiting = 1; done_due = cyc + L + 1;
        end
        next_pix++;
      end
      if (abort) begin
        m_reading = 0; m_waiting = 0;
      end else if (was_idle && start) begin
        m_reading = 1; next_pix = 0; m_nrd = 0;
      end
      m_wr_en = 0;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        m_wr_en = 1; m_wr_addr = q_addr[0];
        void'(q_due.pop_front()); void'(q_addr.pop_front());
      end
    end
    m_busy = m_reading || (m_waiting && cyc < done_due);
  endtask

  task automatic step(input bit s, input bit a, input bit r);
    @(posedge clk); #1;
    model_edge();
    start = s; abort = a; reset = r;
    case (gmode)
      0: mem_grant = 1'b1;
      1: mem_grant = (cyc % 3) != 2;
      default: mem_grant = ($urandom_range(0, 3) != 0);
    endcase
    m_done = m_waiting && (cyc == done_due) && !abort;
  endtask

  // Issue a start pulse and advance until the model has taken it.
  int start_edge;
  task automatic do_start();
    step(1, 0, 0);
    start_edge = cyc + 1;
    step(0, 0, 0);
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((m_reading || m_waiting) && n < maxc) begin step(0, 0, 0); n++; end
    chk("pass_timeout", int'(m_reading || m_waiting), 0);
  endtask

  task automatic wait_nrd(input int k, input int maxc);
    int n = 0;
    while (m_nrd < k && n < maxc) begin step(0, 0, 0); n++; end
    chk("read_wait_timeout", int'(m_nrd >= k), 1);
  endtask

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("rd_en", int'(rd_en), int'(m_rd_en));
      chk("rd_addr", int'(rd_addr), m_rd_addr);
      chk("pix_x", int'(pix_x), m_px);
      chk("pix_y", int'(pix_y), m_py);
      chk("wr_en", int'(wr_en), int'(m_wr_en));
      if (m_wr_en) chk("wr_addr", int'(wr_addr), m_wr_addr);
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("frame_count", int'(frame_count), m_fc);
      if (rd_en) begin
        if (obs_rd == 0) begin first_rd_cyc = cyc; first_rd_addr = int'(rd_addr); end
        last_rd_cyc = cyc; obs_rd++;
      end
      if (wr_en) begin
        if (obs_wr == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc; obs_wr++;
        if (cyc >= cut_edge) late_wr++;
      end
      if (done) begin done_cyc = cyc; obs_done++; end
    end
  end

  initial begin
    reset = 1; start = 0; abort = 0; mem_grant = 1;
    m_reading = 0; m_waiting = 0; next_pix = 0; done_due = -10; m_fc = 0; m_nrd = 0;
    m_rd_en = 0; m_wr_en = 0; m_busy = 0; m_done = 0;
    m_rd_addr = 0; m_px = 0; m_py = 0; m_wr_addr = 0;
    clear_obs();
    step(0, 0, 1);
    chk_on = 1;
    step(0, 0, 0);
    chk("reset_rd_en", int'(rd_en), 0);
    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_count", int'(frame_count), 0);
    step(0, 0, 0);

    // Pass A: grant always high
    gmode = 0; clear_obs();
    do_start();
    wait_idle(100);
    chk("A_reads", obs_rd, 12);
    chk("A_writes", obs_wr, 12);
    chk("A_dones", obs_done, 1);
    chk("A_start_to_rd", first_rd_cyc - start_edge, 1);
    chk("A_read_span", last_rd_cyc - first_rd_cyc, 11);
    chk("A_rd_to_wr", first_wr_cyc - first_rd_cyc, 3);
    chk("A_wr_to_done", done_cyc - last_wr_cyc, 1);
    chk("A_frame_count", int'(frame_count), 1);
    chk("A_model_fc", m_fc, 1);
    step(0, 0, 0);

    // Pass B: grant low every third cycle
    gmode = 1; clear_obs();
    do_start();
    wait_idle(100);
    chk("B_writes", obs_wr, 12);
    chk("B_dones", obs_done, 1);
    chk("B_gaps", int'(last_rd_cyc - first_rd_cyc > 11), 1);
    chk("B_wr_to_done", done_cyc - last_wr_cyc, 1);
    chk("B_frame_count", int'(frame_count), 2);

    // Pass C: stray start mid-pass
    gmode = 0; clear_obs();
    do_start();
    wait_nrd(5, 50);
    step(1, 0, 0);
    step(0, 0, 0);
    wait_idle(100);
    chk("C_writes", obs_wr, 12);
    chk("C_dones", obs_done, 1);
    chk("C_frame_count", int'(frame_count), 3);

    // Abort after the 7th read
    clear_obs();
    do_start();
    wait_nrd(7, 50);
    step(0, 1, 0);
    cut_edge = cyc + 1;
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    chk("abort_late_writes", late_wr, 0);
    chk("abort_dones", obs_done, 0);
    chk("abort_frame_count", int'(frame_count), 3);
    clear_obs();
    do_start();
    wait_idle(100);
    chk("restart_first_addr", first_rd_addr, 0);
    chk("restart_writes", obs_wr, 12);
    chk("restart_frame_count", int'(frame_count), 4);

    // Reset during DRAIN
    clear_obs();
    do_start();
    begin
      int n = 0;
      while (!m_waiting && n < 50) begin step(0, 0, 0); n++; end
      chk("drain_wait_timeout", int'(m_waiting), 1);
    end
    step(0, 0, 1);
    cut_edge = cyc + 1;
    step(0, 0, 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    chk("rst_late_writes", late_wr, 0);
    chk("rst_dones", obs_done, 0);

    // Randomised traffic
    gmode = 2;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 499) == 0);
    gmode = 0;
    for (int i = 0; i < 40; i++) step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
Sequences one gray-scale frame pass through the pixel convolution/filter engine.
- On start, issues one read per pixel in raster order to the frame-buffer read port, gated by the memory arbiter grant.
- Delays each issued address through a fixed-latency pipeline (memory read latency plus engine latency) and issues the matching write to the output frame buffer.
- Sits between the frame-buffer arbiter and the filter datapath; the pixel data path itself stays external.

Parameters:
FRAME_W, 640, pixels per line
FRAME_H, 480, lines per frame
ADDR_W, 19, address width; must satisfy 2**ADDR_W >= FRAME_W*FRAME_H
RD_LAT, 2, cycles from rd_en to read data valid at engine input
ENG_LAT, 1, cycles from engine input to engine result
CNT_W, 16, width of frame_count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; begin a frame pass (honoured only in IDLE)
abort  in  1  cancel the current pass; return to IDLE
mem_grant  in  1  arbiter grant; a read may issue only when high
rd_en  out  1  read strobe to source frame buffer
rd_addr  out  ADDR_W  read address, y*FRAME_W+x
pix_x  out  $clog2(FRAME_W)  column of the read being issued (for border handling)
pix_y  out  $clog2(FRAME_H)  row of the read being issued
wr_en  out  1  write strobe to destination frame buffer
wr_addr  out  ADDR_W  write address
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse when the last write has issued
frame_count  out  CNT_W  completed frames, wraps at 2**CNT_W

Behaviour:
- Reset values: all outputs 0, state IDLE, all pipeline valid bits cleared, x=y=0.
- States:
  - IDLE: start=1 goes to RUN with x=y=0.
  - RUN: each cycle with mem_grant=1, assert rd_en with the current address and advance x. At x=FRAME_W-1, x goes to 0 and y increments. The read of the last pixel (FRAME_W*FRAME_H-1) goes to DRAIN.
  - DRAIN: wait until the pipeline holds no valid entries, then go to DONE.
  - DONE: assert done for 1 cycle, increment frame_count, go to IDLE.
- Registered read outputs: rd_en, rd_addr, pix_x and pix_y change together on the clock edge. rd_en=0 whenever mem_grant=0 or the state is not RUN. Address and coordinates hold when rd_en=0.
- Write timing: wr_en/wr_addr are rd_en/rd_addr delayed by exactly L=RD_LAT+ENG_LAT cycles, with a fixed shift register of valid+address. mem_grant has no effect on in-flight entries. Gaps in rd_en reproduce as identical gaps in wr_en.
- Write count: exactly FRAME_W*FRAME_H writes per pass, no duplicates, ascending addresses.
- done timing: the done pulse occurs 1 cycle after the final wr_en. busy is low in DONE and IDLE.
- start handling: start in RUN, DRAIN or DONE is ignored (no restart, no queueing).
- abort: any state goes to IDLE next cycle.
  - Clears all pipeline valid bits, so no further wr_en.
  - No done pulse; frame_count unchanged.
  - abort and start in the same cycle in IDLE: abort wins.
- Reset mid-frame: identical to abort, and additionally clears frame_count.
- Arithmetic: rd_addr is computed incrementally (add 1 per issued read), not by multiply. It never exceeds FRAME_W*FRAME_H-1.
- frame_count: wraps modulo 2**CNT_W.
- Latency from start to first rd_en: 1 cycle if mem_grant=1.
- Zero-latency case: L=0 must elaborate, with wr_en equal to rd_en in the same cycle.

Decomposition:
- Package conv_seq_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - default FRAME_W/FRAME_H constants;
  - a function computing ADDR_W from frame dimensions.
- Sub-module valid_addr_delay (parameters DEPTH, ADDR_W) implements the shift register:
  - synchronous flush input;
  - an any_valid output used for DRAIN exit.

Test Plan:
- Run FRAME_W=4, FRAME_H=3, RD_LAT=2, ENG_LAT=1 with mem_grant tied high, start pulse → rd_en for 12 consecutive cycles, addresses 0..11. wr_en for addresses 0..11 starts 3 cycles after the first rd_en. done pulses 1 cycle after the write of address 11. frame_count goes 0→1.
- Same setup, mem_grant low on every 3rd cycle → reads skip those cycles with no address skipped. Writes mirror the gaps 3 cycles later. Total 12 writes; done still follows the last write.
- Check coordinates: pix_x/pix_y sequence is (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2). rd_addr equals y*4+x on every rd_en.
- Pulse start again at read #5 → ignored; the pass completes normally with exactly 12 writes and one done.
- Assert abort after the 7th read → no wr_en from the next cycle on, no done, frame_count unchanged. A new start then re-issues from address 0.
- Assert reset during DRAIN → all outputs 0 next cycle, frame_count=0, and no pending write appears afterward.
